// File: rtl/chip8_pkg.sv
// Shared chip-8 video/memory definitions used by the sprite engine and its memory responder.
package chip8_pkg;

  // Request type encoding on mem_type_in, shared with the initiator side.
  localparam logic VIDEO_MEM_TYPE_RAM  = 1'b0;
  localparam logic VIDEO_MEM_TYPE_VRAM = 1'b1;

  // VRAM geometry: one bit per pixel, 64x32 display, 8 bytes per row.
  localparam int unsigned VRAM_WIDTH_PX      = 64;
  localparam int unsigned VRAM_HEIGHT_PX     = 32;
  localparam int unsigned VRAM_BYTES_PER_ROW = VRAM_WIDTH_PX / 8;
  localparam int unsigned VRAM_BANK_BYTES    = VRAM_BYTES_PER_ROW * VRAM_HEIGHT_PX;

  // Responder state: idle (accepting) or waiting on a BRAM read.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } resp_state_e;

  // True when any request address bit at or above position aw is set.
  function automatic logic upper_bits_set(input logic [15:0] addr, input int unsigned aw);
    return (addr >> aw) != 16'd0;
  endfunction

endpackage

// File: rtl/chip8_bram_sp.sv
// Single-port byte-wide BRAM model with a configurable read latency (1..3 cycles).
module chip8_bram_sp #(
  parameter int AW      = 12,
  parameter int LATENCY = 2
) (
  input  logic          clk_in,
  input  logic          en_in,
  input  logic          we_in,
  input  logic [AW-1:0] addr_in,
  input  logic [7:0]    din_in,
  output logic [7:0]    dout_out
);

  logic [7:0] mem [0:(2**AW)-1];
  logic [7:0] pipe_q [LATENCY];

  // Write port plus read pipeline; data appears LATENCY edges after the enable edge.
  // NOTE: the array and read pipeline have no reset -- block RAM contents cannot be
  // cleared by a reset line, and adding one would stop the array mapping to a BRAM.
  always_ff @(posedge clk_in) begin
    if (en_in && we_in) begin
      mem[addr_in] <= din_in;
    end
    if (en_in && !we_in) begin
      pipe_q[0] <= mem[addr_in];
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout_out = pipe_q[LATENCY-1];

endmodule

// File: rtl/chip8_mem_responder.sv
// Responder for the chip-8 sprite/clear engine memory interface: routes requests to
// main RAM or the double-buffered VRAM and returns read data with a one-cycle pulse.
module chip8_mem_responder
  import chip8_pkg::*;
#(
  parameter int BRAM_LATENCY = 2,
  parameter int RAM_AW       = 12,
  parameter int VRAM_AW      = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               ad_in,
  input  logic               mem_valid_in,
  input  logic               mem_we_in,
  input  logic               mem_type_in,
  input  logic [15:0]        mem_addr_in,
  input  logic [7:0]         mem_data_in,
  output logic               mem_ready_out,
  output logic               mem_valid_out,
  output logic [7:0]         mem_data_out,
  output logic               addr_err_out,
  output logic [RAM_AW-1:0]  ram_addr_out,
  output logic               ram_en_out,
  output logic               ram_we_out,
  output logic [7:0]         ram_din_out,
  input  logic [7:0]         ram_dout_in,
  output logic [VRAM_AW:0]   vram_addr_out,
  output logic               vram_en_out,
  output logic               vram_we_out,
  output logic [7:0]         vram_din_out,
  input  logic [7:0]         vram_dout_in
);

  // Counter value on the edge where the selected BRAM output is valid.
  localparam logic [1:0] LAT_LAST = 2'(BRAM_LATENCY);

  resp_state_e state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        type_q, type_d;

  logic               ready_d, valid_d, err_d;
  logic [7:0]         data_d;
  logic [RAM_AW-1:0]  ram_addr_d;
  logic               ram_en_d, ram_we_d;
  logic [7:0]         ram_din_d;
  logic [VRAM_AW:0]   vram_addr_d;
  logic               vram_en_d, vram_we_d;
  logic [7:0]         vram_din_d;

  logic accept;
  assign accept = mem_valid_in && mem_ready_out;

  // Next-state and next-output logic for the responder.
  // NOTE: every signal gets its hold/idle value first so no path leaves one
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    type_d      = type_q;
    ready_d     = mem_ready_out;
    valid_d     = 1'b0;
    data_d      = mem_data_out;
    err_d       = addr_err_out;
    ram_addr_d  = ram_addr_out;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_din_d   = ram_din_out;
    vram_addr_d = vram_addr_out;
    vram_en_d   = 1'b0;
    vram_we_d   = 1'b0;
    vram_din_d  = vram_din_out;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (upper_bits_set(mem_addr_in,
                             (mem_type_in == VIDEO_MEM_TYPE_VRAM) ? VRAM_AW : RAM_AW)) begin
            err_d = 1'b1;
          end
          if (mem_type_in == VIDEO_MEM_TYPE_RAM) begin
            ram_en_d   = 1'b1;
            ram_we_d   = mem_we_in;
            ram_addr_d = mem_addr_in[RAM_AW-1:0];
            ram_din_d  = mem_data_in;
          end else begin
            vram_en_d   = 1'b1;
            vram_we_d   = mem_we_in;
            vram_addr_d = {ad_in, mem_addr_in[VRAM_AW-1:0]};
            vram_din_d  = mem_data_in;
          end
          // Writes complete in the BRAM with nothing to return, so only reads block.
          if (!mem_we_in) begin
            ready_d = 1'b0;
            type_d  = mem_type_in;
            cnt_d   = 2'd0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == LAT_LAST) begin
          data_d  = (type_q == VIDEO_MEM_TYPE_VRAM) ? vram_dout_in : ram_dout_in;
          valid_d = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered-output flops; reset discards any outstanding read.
  // NOTE: non-blocking assignments here so every flop samples pre-edge values,
  // regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      cnt_q         <= 2'd0;
      type_q        <= VIDEO_MEM_TYPE_RAM;
      mem_ready_out <= 1'b1;
      mem_valid_out <= 1'b0;
      mem_data_out  <= 8'h00;
      addr_err_out  <= 1'b0;
      ram_addr_out  <= '0;
      ram_en_out    <= 1'b0;
      ram_we_out    <= 1'b0;
      ram_din_out   <= 8'h00;
      vram_addr_out <= '0;
      vram_en_out   <= 1'b0;
      vram_we_out   <= 1'b0;
      vram_din_out  <= 8'h00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      type_q        <= type_d;
      mem_ready_out <= ready_d;
      mem_valid_out <= valid_d;
      mem_data_out  <= data_d;
      addr_err_out  <= err_d;
      ram_addr_out  <= ram_addr_d;
      ram_en_out    <= ram_en_d;
      ram_we_out    <= ram_we_d;
      ram_din_out   <= ram_din_d;
      vram_addr_out <= vram_addr_d;
      vram_en_out   <= vram_en_d;
      vram_we_out   <= vram_we_d;
      vram_din_out  <= vram_din_d;
    end
  end

endmodule

// File: tb/tb_chip8_mem_responder.sv
// Directed bench: a default-latency responder and a BRAM_LATENCY=1 responder,
// each wired to its own RAM and VRAM models.
module tb_chip8_mem_responder;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // ---------------- default build (BRAM_LATENCY = 2) ----------------
  logic        ad_in = 1'b0;
  logic        mem_valid_in = 1'b0, mem_we_in = 1'b0, mem_type_in = 1'b0;
  logic [15:0] mem_addr_in = 16'h0;
  logic [7:0]  mem_data_in = 8'h0;
  logic        mem_ready_out, mem_valid_out, addr_err_out;
  logic [7:0]  mem_data_out;
  logic [11:0] ram_addr_out;
  logic        ram_en_out, ram_we_out;
  logic [7:0]  ram_din_out, ram_dout_in;
  logic [8:0]  vram_addr_out;
  logic        vram_en_out, vram_we_out;
  logic [7:0]  vram_din_out, vram_dout_in;

  chip8_mem_responder #(.BRAM_LATENCY(2), .RAM_AW(12), .VRAM_AW(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .ad_in(ad_in),
    .mem_valid_in(mem_valid_in), .mem_we_in(mem_we_in), .mem_type_in(mem_type_in),
    .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in),
    .mem_ready_out(mem_ready_out), .mem_valid_out(mem_valid_out),
    .mem_data_out(mem_data_out), .addr_err_out(addr_err_out),
    .ram_addr_out(ram_addr_out), .ram_en_out(ram_en_out), .ram_we_out(ram_we_out),
    .ram_din_out(ram_din_out), .ram_dout_in(ram_dout_in),
    .vram_addr_out(vram_addr_out), .vram_en_out(vram_en_out), .vram_we_out(vram_we_out),
    .vram_din_out(vram_din_out), .vram_dout_in(vram_dout_in)
  );

  chip8_bram_sp #(.AW(12), .LATENCY(2)) u_ram (
    .clk_in(clk_in), .en_in(ram_en_out), .we_in(ram_we_out), .addr_in(ram_addr_out),
    .din_in(ram_din_out), .dout_out(ram_dout_in)
  );

  chip8_bram_sp #(.AW(9), .LATENCY(2)) u_vram (
    .clk_in(clk_in), .en_in(vram_en_out), .we_in(vram_we_out), .addr_in(vram_addr_out),
    .din_in(vram_din_out), .dout_out(vram_dout_in)
  );

  // ---------------- fast build (BRAM_LATENCY = 1) ----------------
  logic        f_ad = 1'b0;
  logic        f_valid_in = 1'b0, f_we = 1'b0, f_type = 1'b0;
  logic [15:0] f_addr = 16'h0;
  logic [7:0]  f_wdata = 8'h0;
  logic        f_ready, f_valid_out, f_err;
  logic [7:0]  f_rdata;
  logic [11:0] f_ram_addr;
  logic        f_ram_en, f_ram_we;
  logic [7:0]  f_ram_din, f_ram_dout;
  logic [8:0]  f_vram_addr;
  logic        f_vram_en, f_vram_we;
  logic [7:0]  f_vram_din, f_vram_dout;

  chip8_mem_responder #(.BRAM_LATENCY(1), .RAM_AW(12), .VRAM_AW(8)) dut_fast (
    .clk_in(clk_in), .rst_in(rst_in), .ad_in(f_ad),
    .mem_valid_in(f_valid_in), .mem_we_in(f_we), .mem_type_in(f_type),
    .mem_addr_in(f_addr), .mem_data_in(f_wdata),
    .mem_ready_out(f_ready), .mem_valid_out(f_valid_out),
    .mem_data_out(f_rdata), .addr_err_out(f_err),
    .ram_addr_out(f_ram_addr), .ram_en_out(f_ram_en), .ram_we_out(f_ram_we),
    .ram_din_out(f_ram_din), .ram_dout_in(f_ram_dout),
    .vram_addr_out(f_vram_addr), .vram_en_out(f_vram_en), .vram_we_out(f_vram_we),
    .vram_din_out(f_vram_din), .vram_dout_in(f_vram_dout)
  );

  chip8_bram_sp #(.AW(12), .LATENCY(1)) u_ram_fast (
    .clk_in(clk_in), .en_in(f_ram_en), .we_in(f_ram_we), .addr_in(f_ram_addr),
    .din_in(f_ram_din), .dout_out(f_ram_dout)
  );

  chip8_bram_sp #(.AW(9), .LATENCY(1)) u_vram_fast (
    .clk_in(clk_in), .en_in(f_vram_en), .we_in(f_vram_we), .addr_in(f_vram_addr),
    .din_in(f_vram_din), .dout_out(f_vram_dout)
  );

  // Compare one observed value against its hand-computed expectation.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Present one request on the default build.
  task automatic req(input logic we, input logic typ, input logic [15:0] addr,
                     input logic [7:0] data, input logic ad);
    mem_valid_in = 1'b1;
    mem_we_in    = we;
    mem_type_in  = typ;
    mem_addr_in  = addr;
    mem_data_in  = data;
    ad_in        = ad;
  endtask

  // Present one request on the fast build.
  task automatic freq(input logic we, input logic [15:0] addr, input logic [7:0] data);
    f_valid_in = 1'b1;
    f_we       = we;
    f_type     = 1'b0;
    f_addr     = addr;
    f_wdata    = data;
  endtask

  initial begin
    // ---- reset state ----
    tick();
    check("rst_ready", 32'(mem_ready_out), 32'd1);
    check("rst_valid", 32'(mem_valid_out), 32'd0);
    check("rst_data",  32'(mem_data_out),  32'h00);
    check("rst_err",   32'(addr_err_out),  32'd0);
    check("rst_ram_en",  32'(ram_en_out),  32'd0);
    check("rst_vram_en", 32'(vram_en_out), 32'd0);
    check("rst_vram_addr", 32'(vram_addr_out), 32'h000);
    rst_in = 1'b0;
    tick();

    // ---- preload RAM[0x200]=0xF0 and VRAM bank0[0x13]=0xA5 ----
    req(1'b1, 1'b0, 16'h0200, 8'hF0, 1'b0);
    tick();
    check("wr_ram_en",   32'(ram_en_out),   32'd1);
    check("wr_ram_we",   32'(ram_we_out),   32'd1);
    check("wr_ram_addr", 32'(ram_addr_out), 32'h200);
    check("wr_ram_vram_en", 32'(vram_en_out), 32'd0);
    check("wr_ready",    32'(mem_ready_out), 32'd1);
    req(1'b1, 1'b1, 16'h0013, 8'hA5, 1'b0);
    tick();
    check("wr_vram_addr", 32'(vram_addr_out), 32'h013);
    check("wr_vram_we",   32'(vram_we_out),   32'd1);
    check("wr_vram_ram_en", 32'(ram_en_out),  32'd0);
    mem_valid_in = 1'b0;

    // ---- RAM read of 0x200 at default latency ----
    tick();
    req(1'b0, 1'b0, 16'h0200, 8'h00, 1'b0);
    tick();                                  // acceptance edge
    mem_valid_in = 1'b0;
    check("rd_ready_c0", 32'(mem_ready_out), 32'd0);
    check("rd_ram_en_c0", 32'(ram_en_out),   32'd1);
    check("rd_ram_we_c0", 32'(ram_we_out),   32'd0);
    check("rd_ram_addr",  32'(ram_addr_out), 32'h200);
    check("rd_valid_c0",  32'(mem_valid_out), 32'd0);
    tick();
    check("rd_ram_en_c1", 32'(ram_en_out),   32'd0);
    check("rd_ready_c1",  32'(mem_ready_out), 32'd0);
    check("rd_valid_c1",  32'(mem_valid_out), 32'd0);
    tick();
    check("rd_ready_c2",  32'(mem_ready_out), 32'd0);
    check("rd_valid_c2",  32'(mem_valid_out), 32'd0);
    tick();
    check("rd_valid_c3",  32'(mem_valid_out), 32'd1);
    check("rd_data_c3",   32'(mem_data_out),  32'hF0);
    check("rd_ready_c3",  32'(mem_ready_out), 32'd1);
    tick();
    check("rd_valid_c4",  32'(mem_valid_out), 32'd0);
    check("rd_data_hold", 32'(mem_data_out),  32'hF0);

    // ---- 256 back-to-back VRAM writes of 0x00 into bank 1 ----
    for (int i = 0; i < 256; i++) begin
      req(1'b1, 1'b1, 16'(i), 8'h00, 1'b1);
      tick();
      check("burst_vram_addr", 32'(vram_addr_out), 32'h100 + 32'(i));
      check("burst_vram_we",   32'(vram_we_out),   32'd1);
      check("burst_ready",     32'(mem_ready_out), 32'd1);
    end
    mem_valid_in = 1'b0;
    tick();
    check("burst_end_en", 32'(vram_en_out), 32'd0);

    // ---- VRAM read of 0x13 from bank 0, ad_in flips during the read ----
    req(1'b0, 1'b1, 16'h0013, 8'h00, 1'b0);
    tick();
    mem_valid_in = 1'b0;
    ad_in        = 1'b1;
    check("vrd_addr", 32'(vram_addr_out), 32'h013);
    check("vrd_en",   32'(vram_en_out),   32'd1);
    tick();
    tick();
    check("vrd_valid_c2", 32'(mem_valid_out), 32'd0);
    tick();
    check("vrd_valid_c3", 32'(mem_valid_out), 32'd1);
    check("vrd_data_bank0", 32'(mem_data_out), 32'hA5);

    // ---- out-of-range address: 0x1200 reads RAM 0x200 and sets the sticky error ----
    tick();
    check("err_before", 32'(addr_err_out), 32'd0);
    req(1'b0, 1'b0, 16'h1200, 8'h00, 1'b0);
    tick();
    mem_valid_in = 1'b0;
    check("err_ram_addr", 32'(ram_addr_out), 32'h200);
    check("err_set", 32'(addr_err_out), 32'd1);
    tick();
    tick();
    tick();
    check("err_rd_valid", 32'(mem_valid_out), 32'd1);
    check("err_rd_data",  32'(mem_data_out),  32'hF0);
    req(1'b1, 1'b0, 16'h0300, 8'h77, 1'b0);
    tick();
    mem_valid_in = 1'b0;
    check("err_sticky_wr", 32'(addr_err_out), 32'd1);
    tick();
    check("err_sticky_idle", 32'(addr_err_out), 32'd1);

    // ---- reset during WAIT discards the read ----
    req(1'b0, 1'b0, 16'h0200, 8'h00, 1'b0);
    tick();
    mem_valid_in = 1'b0;
    tick();
    rst_in = 1'b1;
    #1;
    check("mid_rst_ready", 32'(mem_ready_out), 32'd1);
    check("mid_rst_valid", 32'(mem_valid_out), 32'd0);
    check("mid_rst_err",   32'(addr_err_out),  32'd0);
    check("mid_rst_data",  32'(mem_data_out),  32'h00);
    tick();
    rst_in = 1'b0;
    tick();
    check("post_rst_valid_a", 32'(mem_valid_out), 32'd0);
    tick();
    check("post_rst_valid_b", 32'(mem_valid_out), 32'd0);
    check("post_rst_ready",   32'(mem_ready_out), 32'd1);
    req(1'b0, 1'b1, 16'h0013, 8'h00, 1'b0);
    tick();
    mem_valid_in = 1'b0;
    tick();
    tick();
    tick();
    check("post_rst_rd_valid", 32'(mem_valid_out), 32'd1);
    check("post_rst_rd_data",  32'(mem_data_out),  32'hA5);

    // ---- BRAM_LATENCY=1 build: back-to-back reads ----
    freq(1'b1, 16'h0010, 8'h11);
    tick();
    freq(1'b1, 16'h0011, 8'h22);
    tick();
    f_valid_in = 1'b0;
    tick();
    freq(1'b0, 16'h0010, 8'h00);
    tick();                                  // acceptance of read A
    f_valid_in = 1'b0;
    check("fast_a_ready_c0", 32'(f_ready), 32'd0);
    tick();
    check("fast_a_valid_c1", 32'(f_valid_out), 32'd0);
    tick();
    check("fast_a_valid_c2", 32'(f_valid_out), 32'd1);
    check("fast_a_data",     32'(f_rdata),     32'h11);
    check("fast_a_ready_c2", 32'(f_ready),     32'd1);
    freq(1'b0, 16'h0011, 8'h00);             // issued in the valid cycle
    tick();                                  // acceptance of read B
    f_valid_in = 1'b0;
    check("fast_b_valid_c0", 32'(f_valid_out), 32'd0);
    check("fast_b_ready_c0", 32'(f_ready),     32'd0);
    check("fast_b_addr",     32'(f_ram_addr),  32'h011);
    tick();
    check("fast_b_valid_c1", 32'(f_valid_out), 32'd0);
    tick();
    check("fast_b_valid_c2", 32'(f_valid_out), 32'd1);
    check("fast_b_data",     32'(f_rdata),     32'h22);
    check("fast_err",        32'(f_err),       32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
